cur_mb_loader: RTL and testbench

CUR_MB_LOADER -- requirements
Module: cur_mb_loader

---
 rtl/cur_mb_loader.sv | 131 +++++++++++++
 tb/tb_cur_mb_loader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cur_mb_loader.sv
// rtl/cur_mb_loader.sv - current-frame macroblock loader: 64-word fetch, 16-row stream out
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - asynchronous active-high reset
//   start      - frame start request, sampled only while idle
//   read_en    - word request to the current-frame memory (64 cycles per MB)
//   cur_data   - 32-bit frame word, valid in the cycle read_en is high, byte 0 = lowest pixel
//   row_valid  - row_data/row_idx/mb_idx hold a valid MB row
//   row_ready  - consumer accepts the row
//   row_data   - 16 pixels of one MB row, pixel k at bits 8k+7:8k
//   row_idx    - row number within the MB
//   mb_idx     - MB number within the frame
//   busy       - high whenever not idle
//   frame_done - one-cycle pulse after the last row of the frame is accepted
module cur_mb_loader #(
    parameter int NUM_MB = 8160
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         read_en,
    input  logic [31:0]  cur_data,
    output logic         row_valid,
    input  logic         row_ready,
    output logic [127:0] row_data,
    output logic [3:0]   row_idx,
    output logic [15:0]  mb_idx,
    output logic         busy,
    output logic         frame_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam logic [15:0] LAST_MB = 16'(NUM_MB - 1);

    state_t       state;
    logic [5:0]   word_cnt;
    logic [127:0] mb_buf [16];
    logic         transfer;

    assign transfer = row_valid && row_ready;

    // MB pixel buffer. Not reset: row_data is masked until the first SEND.
    // Word w lands in row w/4, lane w%4 (lane 0 = pixels 0..3).
    always_ff @(posedge clk) begin
        if (read_en) begin
            mb_buf[word_cnt[5:2]][{word_cnt[1:0], 5'd0} +: 32] <= cur_data;
        end
    end

    // Masking with row_valid keeps row_data at zero in reset and before the
    // first row without needing to clear the buffer.
    always_comb begin
        row_data = '0;
        if (row_valid) begin
            row_data = mb_buf[row_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            read_en    <= 1'b0;
            row_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            row_idx    <= 4'd0;
            mb_idx     <= 16'd0;
            word_cnt   <= 6'd0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        read_en  <= 1'b1;
                        busy     <= 1'b1;
                        mb_idx   <= 16'd0;
                        word_cnt <= 6'd0;
                        row_idx  <= 4'd0;
                    end
                end

                LOAD: begin
                    // read_en is high for the whole of LOAD; each edge captures one word.
                    // word_cnt wraps from 63 back to 0, ready for the next MB.
                    word_cnt <= word_cnt + 6'd1;
                    if (word_cnt == 6'd63) begin
                        state     <= SEND;
                        read_en   <= 1'b0;
                        row_valid <= 1'b1;
                        row_idx   <= 4'd0;
                    end
                end

                SEND: begin
                    if (transfer) begin
                        if (row_idx != 4'd15) begin
                            row_idx <= row_idx + 4'd1;
                        end else begin
                            row_valid <= 1'b0;
                            row_idx   <= 4'd0;
                            if (mb_idx == LAST_MB) begin
                                state      <= IDLE;
                                busy       <= 1'b0;
                                frame_done <= 1'b1;
                            end else begin
                                state   <= LOAD;
                                read_en <= 1'b1;
                                mb_idx  <= mb_idx + 16'd1;
                            end
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    read_en   <= 1'b0;
                    row_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cur_mb_loader.sv
// tb/tb_cur_mb_loader.sv - self-checking bench for cur_mb_loader
module tb_cur_mb_loader;

    logic         clk;
    logic         rst = 1'b0;

    logic         start;
    logic         read_en;
    logic [31:0]  cur_data;
    logic         row_valid;
    logic         row_ready;
    logic [127:0] row_data;
    logic [3:0]   row_idx;
    logic [15:0]  mb_idx;
    logic         busy;
    logic         frame_done;

    logic         start1;
    logic         read_en1;
    logic [31:0]  cur_data1;
    logic         row_valid1;
    logic         row_ready1;
    logic [127:0] row_data1;
    logic [3:0]   row_idx1;
    logic [15:0]  mb_idx1;
    logic         busy1;
    logic         frame_done1;

    int total = 0;
    int bad   = 0;

    logic [31:0] words [2][64];

    cur_mb_loader #(.NUM_MB(2)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .read_en    (read_en),
        .cur_data   (cur_data),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_data   (row_data),
        .row_idx    (row_idx),
        .mb_idx     (mb_idx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    cur_mb_loader #(.NUM_MB(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .start      (start1),
        .read_en    (read_en1),
        .cur_data   (cur_data1),
        .row_valid  (row_valid1),
        .row_ready  (row_ready1),
        .row_data   (row_data1),
        .row_idx    (row_idx1),
        .mb_idx     (mb_idx1),
        .busy       (busy1),
        .frame_done (frame_done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pixels are the frame bytes in address order; row r holds bytes 16r..16r+15.
    function automatic logic [127:0] build_row(input int mb, input int r);
        logic [127:0] row;
        int n;
        row = '0;
        for (int k = 0; k < 16; k++) begin
            n = 16 * r + k;
            row[8*k +: 8] = words[mb][n/4][8*(n%4) +: 8];
        end
        return row;
    endfunction

    // mode 0: word index replicated, 1: random, 2: 32'h44332211
    task automatic run_frame(input int mode, input int ready_pct, input bit rand_start);
        logic [127:0] exp_q[$];
        int   cyc, w, mb, rd_run, stalls, done_cyc, popped;
        logic prev_rd;
        bit   done;

        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 64; i++) begin
                case (mode)
                    0:       words[m][i] = {4{8'(i)}};
                    1:       words[m][i] = $urandom;
                    default: words[m][i] = 32'h44332211;
                endcase
            end
        end
        exp_q = {};
        for (int m = 0; m < 2; m++)
            for (int r = 0; r < 16; r++)
                exp_q.push_back(build_row(m, r));

        start = 1'b1;
        row_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 128'(busy), 128'(1));
        chk("read_en_after_start", 128'(read_en), 128'(1));
        chk("mb_idx_at_start", 128'(mb_idx), 128'(0));

        cyc = 0; w = 0; mb = 0; rd_run = 0; stalls = 0; done_cyc = -1; popped = 0;
        prev_rd = 1'b1; done = 1'b0;
        while (!done) begin
            if (frame_done) begin
                done = 1'b1;
                done_cyc = cyc;
                chk("busy_at_done", 128'(busy), 128'(0));
                chk("row_valid_at_done", 128'(row_valid), 128'(0));
                chk("read_en_at_done", 128'(read_en), 128'(0));
            end else if (cyc >= 3000) begin
                done = 1'b1;
                total++;
                bad++;
                $error("FAIL frame_timeout observed=%0d cycles without frame_done", cyc);
            end else begin
                if (prev_rd && !read_en) begin
                    chk("read_en_run_len", 128'(rd_run), 128'(64));
                    chk("first_row_latency", 128'(row_valid), 128'(1));
                    rd_run = 0;
                end
                chk("read_en_row_valid_excl", 128'(read_en & row_valid), 128'(0));
                if (read_en) begin
                    cur_data = (mb < 2) ? words[mb][w] : 32'hdeadbeef;
                    rd_run++;
                    w++;
                    if (w == 64) begin
                        w = 0;
                        mb++;
                    end
                end else begin
                    cur_data = $urandom;
                end
                row_ready = ($urandom_range(99) < ready_pct);
                if (row_valid) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $error("FAIL extra_row observed=row_idx %0d mb_idx %0d expected=no row", row_idx, mb_idx);
                    end else begin
                        chk("row_data", row_data, exp_q[0]);
                        chk("row_idx", 128'(row_idx), 128'(popped % 16));
                        chk("mb_idx", 128'(mb_idx), 128'(popped / 16));
                        if (mode == 2) begin
                            chk("pixel0_byte", 128'(row_data[7:0]), 128'(8'h11));
                            chk("pixel3_byte", 128'(row_data[31:24]), 128'(8'h44));
                        end
                        if (row_ready) begin
                            void'(exp_q.pop_front());
                            popped++;
                        end else begin
                            stalls++;
                        end
                    end
                end
                start = rand_start ? ($urandom_range(3) == 0) : 1'b0;
                prev_rd = read_en;
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0;
        row_ready = 1'b0;
        chk("rows_transferred", 128'(popped), 128'(32));
        chk("frame_length", 128'(done_cyc), 128'(2 * 80 + stalls));
        @(posedge clk); #1;
        chk("frame_done_one_cycle", 128'(frame_done), 128'(0));
        chk("busy_after_frame", 128'(busy), 128'(0));
    endtask

    initial begin
        int c, n1, r1, fd_cnt, fd_first, fd_second;

        start = 1'b0;
        row_ready = 1'b0;
        cur_data = '0;
        start1 = 1'b0;
        row_ready1 = 1'b0;
        cur_data1 = '0;

        // Reset takes effect before any clock edge.
        #1 rst = 1'b1;
        #1;
        chk("rst_read_en", 128'(read_en), 128'(0));
        chk("rst_row_valid", 128'(row_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_frame_done", 128'(frame_done), 128'(0));
        chk("rst_row_idx", 128'(row_idx), 128'(0));
        chk("rst_mb_idx", 128'(mb_idx), 128'(0));
        chk("rst_row_data", row_data, 128'(0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", 128'(busy), 128'(0));
        chk("idle_row_data", row_data, 128'(0));

        run_frame(0, 100, 1'b0);
        run_frame(1, 50, 1'b1);
        run_frame(2, 70, 1'b0);

        // Abort mid-LOAD while word 30 is on the bus.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        row_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cur_data = $urandom;
            @(posedge clk); #1;
        end
        chk("abort_read_en_before", 128'(read_en), 128'(1));
        #2 rst = 1'b1;
        #1;
        chk("abort_read_en", 128'(read_en), 128'(0));
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_row_valid", 128'(row_valid), 128'(0));
        chk("abort_row_data", row_data, 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("post_abort_idle", 128'({busy, read_en, row_valid, frame_done}), 128'(0));
        end
        run_frame(0, 30, 1'b1);

        // NUM_MB=1 with start held high: back-to-back frames, one idle cycle apart.
        row_ready1 = 1'b1;
        start1 = 1'b1;
        @(posedge clk); #1;
        n1 = 0; r1 = 0; fd_cnt = 0; fd_first = -1; fd_second = -1;
        for (c = 0; c <= 170; c++) begin
            if (c > 0) begin
                if (frame_done1) begin
                    fd_cnt++;
                    if (fd_cnt == 1) fd_first = c;
                    else if (fd_cnt == 2) fd_second = c;
                end
                if (c == 40) chk("held_start_busy", 128'(busy1), 128'(1));
                if (c == 80) chk("held_start_idle_cycle", 128'(busy1), 128'(0));
                if (c == 81) begin
                    chk("held_start_restart_busy", 128'(busy1), 128'(1));
                    chk("held_start_restart_read", 128'(read_en1), 128'(1));
                end
                if (row_valid1) begin
                    logic [127:0] er;
                    for (int k = 0; k < 16; k++) er[8*k +: 8] = 8'(4 * (r1 % 16) + k / 4);
                    chk("nmb1_row_data", row_data1, er);
                    chk("nmb1_mb_idx", 128'(mb_idx1), 128'(0));
                    r1++;
                end
            end
            if (read_en1) begin
                cur_data1 = {4{8'(n1)}};
                n1 = (n1 + 1) % 64;
            end else begin
                cur_data1 = $urandom;
            end
            @(posedge clk); #1;
        end
        start1 = 1'b0;
        chk("nmb1_first_done", 128'(fd_first), 128'(80));
        chk("nmb1_second_done", 128'(fd_second), 128'(161));
        chk("nmb1_done_count", 128'(fd_cnt), 128'(2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
